// File: rtl/note_judge.sv
// rtl/note_judge.sv - per-lane rhythm-game note judge: walks the chart, judges key timing, keeps combo and score
// Optional feature: define NOTE_JUDGE_AUTOPLAY_EN to auto-press every note on time and hold every hold.
module note_judge #(
   parameter int P_WIN     = 3,
   parameter int G_WIN     = 6,
   parameter int CHART_LEN = 108
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        start,
   input  logic        frame_tick,
   input  logic        key_level,
   input  logic [15:0] key_1,
   input  logic [15:0] key_2,
   output logic [7:0]  addr,
   output logic [13:0] song_time,
   output logic        judge_valid,
   output logic [1:0]  judge_code,
   output logic [9:0]  combo,
   output logic [9:0]  max_combo,
   output logic [15:0] score,
   output logic        holding,
   output logic        done
);
   typedef enum logic [1:0] {IDLE, PLAY, HOLD, DONE} state_t;

   localparam logic [1:0] TY_HSTART = 2'b01;
   localparam logic [1:0] TY_END    = 2'b11;
   localparam logic [1:0] J_NONE    = 2'b00;
   localparam logic [1:0] J_PERFECT = 2'b01;
   localparam logic [1:0] J_GOOD    = 2'b10;
   localparam logic [1:0] J_MISS    = 2'b11;
   localparam logic signed [14:0] P_HI = 15'(P_WIN);
   localparam logic signed [14:0] P_LO = -P_HI;
   localparam logic signed [14:0] G_HI = 15'(G_WIN);
   localparam logic signed [14:0] G_LO = -G_HI;
   localparam logic [8:0] LEN9 = 9'(CHART_LEN);

   state_t             state_q, state_d;
   logic [7:0]         addr_q, addr_d;
   logic [13:0]        song_time_q, song_time_d;
   logic               judge_valid_q, judge_valid_d;
   logic [1:0]         judge_code_q, judge_code_d;
   logic [9:0]         combo_q, combo_d;
   logic [9:0]         max_combo_q, max_combo_d;
   logic [15:0]        score_q, score_d;
   logic               holding_q, holding_d;
   logic               done_q, done_d;
   logic               key_q;

   logic [1:0]         head_type;
   logic signed [14:0] delta;
   logic               key_press, key_rel, key_held;
   logic [1:0]         judge;
   logic [8:0]         step, addr_sum;
   logic [16:0]        score_sum;
   logic               unused_key_2;

   assign head_type    = key_1[15:14];
   assign delta        = $signed({1'b0, song_time_q}) - $signed({1'b0, key_1[13:0]});
   // The hold-end is skipped by position alone, so the look-ahead entry carries no needed data.
   assign unused_key_2 = ^key_2;

`ifdef NOTE_JUDGE_AUTOPLAY_EN
   logic unused_key;
   assign unused_key = key_level ^ key_q;
   assign key_press  = (delta == 15'sd0);
   assign key_rel    = 1'b0;
   assign key_held   = 1'b1;
`else
   assign key_press  = key_level & ~key_q;
   assign key_rel    = ~key_level & key_q;
   assign key_held   = key_level;
`endif

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      song_time_d   = song_time_q;
      judge_valid_d = 1'b0;
      judge_code_d  = judge_code_q;
      combo_d       = combo_q;
      max_combo_d   = max_combo_q;
      score_d       = score_q;
      judge         = J_NONE;
      step          = 9'd1;
      addr_sum      = 9'd0;
      score_sum     = 17'd0;

      if (start || state_q == IDLE) begin
         addr_d       = '0;
         song_time_d  = '0;
         judge_code_d = J_NONE;
         combo_d      = '0;
         max_combo_d  = '0;
         score_d      = '0;
         if (start) state_d = PLAY;
      end else if (state_q != DONE) begin
         if (frame_tick && song_time_q != 14'h3FFF) song_time_d = song_time_q + 14'd1;
         if (state_q == PLAY) begin
            if (head_type == TY_END || {1'b0, addr_q} >= LEN9) begin
               state_d = DONE;
            end else if (delta > G_HI) begin
               judge = J_MISS;
               if (head_type == TY_HSTART) step = 9'd2;
            end else if (key_press && delta >= G_LO) begin
               judge = (delta >= P_LO && delta <= P_HI) ? J_PERFECT : J_GOOD;
               if (head_type == TY_HSTART) state_d = HOLD;
            end
         end else begin
            // Letting go on or after the end frame still counts as held through.
            if (delta >= 15'sd0 && (key_held || key_rel)) begin
               judge   = J_PERFECT;
               state_d = PLAY;
            end else if (key_rel) begin
               judge   = (delta >= G_LO) ? J_GOOD : J_MISS;
               state_d = PLAY;
            end
         end
      end

      if (judge != J_NONE) begin
         judge_valid_d = 1'b1;
         judge_code_d  = judge;
         addr_sum      = {1'b0, addr_q} + step;
         addr_d        = (addr_sum > LEN9) ? LEN9[7:0] : addr_sum[7:0];
         if (judge == J_MISS) begin
            combo_d = '0;
         end else begin
            if (combo_q != 10'd1023) combo_d = combo_q + 10'd1;
            score_sum = {1'b0, score_q} + ((judge == J_PERFECT) ? 17'd2 : 17'd1);
            score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
         end
         if (combo_d > max_combo_q) max_combo_d = combo_d;
      end

      holding_d = (state_d == HOLD);
      done_d    = (state_d == DONE);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         song_time_q   <= '0;
         judge_valid_q <= 1'b0;
         judge_code_q  <= J_NONE;
         combo_q       <= '0;
         max_combo_q   <= '0;
         score_q       <= '0;
         holding_q     <= 1'b0;
         done_q        <= 1'b0;
         key_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         song_time_q   <= song_time_d;
         judge_valid_q <= judge_valid_d;
         judge_code_q  <= judge_code_d;
         combo_q       <= combo_d;
         max_combo_q   <= max_combo_d;
         score_q       <= score_d;
         holding_q     <= holding_d;
         done_q        <= done_d;
         key_q         <= key_level;
      end
   end

   assign addr        = addr_q;
   assign song_time   = song_time_q;
   assign judge_valid = judge_valid_q;
   assign judge_code  = judge_code_q;
   assign combo       = combo_q;
   assign max_combo   = max_combo_q;
   assign score       = score_q;
   assign holding     = holding_q;
   assign done        = done_q;
endmodule

// File: tb/tb_note_judge.sv
// tb/tb_note_judge.sv - directed self-checking bench for note_judge with a behavioural chart ROM
module tb_note_judge;
   logic        Clk = 1'b0;
   logic        Reset;
   logic        start;
   logic        frame_tick;
   logic        key_level;
   logic [15:0] key_1, key_2;
   logic [7:0]  addr;
   logic [13:0] song_time;
   logic        judge_valid;
   logic [1:0]  judge_code;
   logic [9:0]  combo, max_combo;
   logic [15:0] score;
   logic        holding, done;

   logic [15:0] mem [0:255];
   int          n_checks = 0;
   int          n_pass   = 0;

   note_judge dut (
      .Clk(Clk), .Reset(Reset), .start(start), .frame_tick(frame_tick),
      .key_level(key_level), .key_1(key_1), .key_2(key_2), .addr(addr),
      .song_time(song_time), .judge_valid(judge_valid), .judge_code(judge_code),
      .combo(combo), .max_combo(max_combo), .score(score), .holding(holding), .done(done)
   );

   always #5 Clk = ~Clk;

   assign key_1 = mem[addr];
   assign key_2 = mem[addr + 8'd1];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic fill(input logic [15:0] v);
      for (int i = 0; i < 256; i++) mem[i] = v;
   endtask

   task automatic restart();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic advance_to(input int target);
      int n = 0;
      frame_tick = 1'b1;
      while (song_time != 14'(target) && n < 20000) begin
         step();
         n++;
      end
      frame_tick = 1'b0;
      check("advance_to", 32'(song_time), 32'(target));
   endtask

   initial begin
      Reset = 1'b0; start = 1'b0; frame_tick = 1'b0; key_level = 1'b0;
      fill(16'hC000);
      repeat (3) step();
      check("rst_addr", 32'(addr), 0);
      check("rst_time", 32'(song_time), 0);
      check("rst_jv", 32'(judge_valid), 0);
      check("rst_jc", 32'(judge_code), 0);
      check("rst_score", 32'(score), 0);
      check("rst_hold_done", {30'd0, holding, done}, 0);
      Reset = 1'b1;
      step();

      // tap hit at T=71
      mem[0] = 16'h0047;
      restart();
      advance_to(71);
      key_level = 1'b1; step();
      check("tap_jv", 32'(judge_valid), 1);
      check("tap_jc", 32'(judge_code), 1);
      check("tap_addr", 32'(addr), 1);
      check("tap_score", 32'(score), 2);
      check("tap_combo", 32'(combo), 1);
      key_level = 1'b0; step();
      check("tap_jv_pulse", 32'(judge_valid), 0);
      check("tap_jc_hold", 32'(judge_code), 1);
      check("tap_done", 32'(done), 1);

      // early press ignored, then GOOD at 95
      fill(16'hC000);
      mem[0] = 16'h0064;
      restart();
      check("rs_addr", 32'(addr), 0);
      check("rs_score", 32'(score), 0);
      check("rs_done", 32'(done), 0);
      advance_to(90);
      key_level = 1'b1; step();
      check("early_jv", 32'(judge_valid), 0);
      check("early_addr", 32'(addr), 0);
      key_level = 1'b0; step();
      advance_to(95);
      key_level = 1'b1; step();
      check("good_jc", 32'(judge_code), 2);
      check("good_score", 32'(score), 1);
      check("good_addr", 32'(addr), 1);
      key_level = 1'b0; step();

      // PERFECT at 50, then timeout MISS on T=100 with a same-cycle press
      fill(16'hC000);
      mem[0] = 16'h0032;
      mem[1] = 16'h0064;
      restart();
      advance_to(50);
      key_level = 1'b1; step();
      check("pre_combo", 32'(combo), 1);
      key_level = 1'b0; step();
      advance_to(107);
      key_level = 1'b1; step();
      check("miss_jv", 32'(judge_valid), 1);
      check("miss_jc", 32'(judge_code), 3);
      check("miss_combo", 32'(combo), 0);
      check("miss_max", 32'(max_combo), 1);
      check("miss_addr", 32'(addr), 2);
      check("miss_score", 32'(score), 2);
      step();
      check("miss_no_second", 32'(judge_valid), 0);
      key_level = 1'b0; step();

      // hold pair held through to the end
      fill(16'hC000);
      mem[0] = 16'h4235;
      mem[1] = 16'h8247;
      restart();
      advance_to(565);
      key_level = 1'b1; step();
      check("hs_jc", 32'(judge_code), 1);
      check("hs_holding", 32'(holding), 1);
      check("hs_addr", 32'(addr), 1);
      advance_to(583);
      step();
      check("he_jv", 32'(judge_valid), 1);
      check("he_jc", 32'(judge_code), 1);
      check("he_holding", 32'(holding), 0);
      check("he_addr", 32'(addr), 2);
      check("he_score", 32'(score), 4);
      check("he_combo", 32'(combo), 2);
      key_level = 1'b0; step();

      // hold released far too early
      restart();
      advance_to(565);
      key_level = 1'b1; step();
      advance_to(570);
      key_level = 1'b0; step();
      check("hr_jc", 32'(judge_code), 3);
      check("hr_holding", 32'(holding), 0);
      check("hr_addr", 32'(addr), 2);
      check("hr_combo", 32'(combo), 0);
      check("hr_max", 32'(max_combo), 1);
      check("hr_score", 32'(score), 2);

      // chart with no end marker: every tap times out until addr reaches CHART_LEN
      fill(16'h0000);
      restart();
      advance_to(7);
      begin
         int n = 0;
         while (!done && n < 400) begin
            step();
            n++;
         end
      end
      check("end_done", 32'(done), 1);
      check("end_addr", 32'(addr), 108);
      check("end_jc", 32'(judge_code), 3);
      frame_tick = 1'b1;
      step(); step();
      frame_tick = 1'b0;
      check("end_frozen_addr", 32'(addr), 108);
      check("end_frozen_time", 32'(song_time), 7);
      restart();
      check("end_rs_addr", 32'(addr), 0);
      check("end_rs_done", 32'(done), 0);
      check("end_rs_jc", 32'(judge_code), 0);

      // asynchronous reset while a hold is active
      fill(16'hC000);
      mem[0] = 16'h4235;
      mem[1] = 16'h8247;
      restart();
      advance_to(565);
      key_level = 1'b1; step();
      check("mid_holding", 32'(holding), 1);
      Reset = 1'b0;
      #2;
      check("ar_holding", 32'(holding), 0);
      check("ar_addr", 32'(addr), 0);
      check("ar_time", 32'(song_time), 0);
      check("ar_score", 32'(score), 0);
      check("ar_combo", {22'd0, combo, max_combo}, 0);
      check("ar_judge", {29'd0, judge_valid, judge_code}, 0);
      check("ar_done", 32'(done), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/note_judge.md
Name: note_judge

Overview:
- Per-lane rhythm-game judging stage; sits directly downstream of the lane chart ROM.
- Drives the ROM read pointer `addr` and consumes the head entry `key_1` plus the next entry `key_2`.
- Entry format: [15:14] type (00 tap, 01 hold-start, 10 hold-end, 11 end marker); [13:0] hit time in video frames (60 Hz).
- Tracks song time, samples the lane key, and emits PERFECT/GOOD/MISS judgements, combo and score to the HUD/score logic.

Parameters:
- P_WIN, 3, perfect window in frames (|delta| <= P_WIN).
- G_WIN, 6, good window in frames (|delta| <= G_WIN); must satisfy G_WIN >= P_WIN.
- CHART_LEN, 108, number of valid entries; `addr` never exceeds this value.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  one-cycle pulse; (re)starts the song.
- frame_tick  in  1  one-cycle pulse per video frame.
- key_level  in  1  lane key held level (already synchronised).
- key_1  in  16  chart head entry.
- key_2  in  16  chart entry after the head.
- addr  out  8  chart read pointer.
- song_time  out  14  current frame count.
- judge_valid  out  1  one-cycle pulse when a judgement is produced.
- judge_code  out  2  judgement: 00 none, 01 PERFECT, 10 GOOD, 11 MISS; holds its value until the next judgement.
- combo  out  10  current combo.
- max_combo  out  10  best combo this song.
- score  out  16  accumulated score.
- holding  out  1  high while a hold note is active.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, Reset=0):
  - State = IDLE.
  - addr, song_time, judge_code, combo, max_combo, score = 0.
  - judge_valid, holding, done = 0.
  - key_q = 0.
- Derived signals:
  - key_q is key_level registered once.
  - press = key_level & ~key_q.
  - release = ~key_level & key_q.
  - T = key_1[13:0].
  - delta = {1'b0,song_time} - {1'b0,T}, a 15-bit signed value.
- IDLE:
  - start -> PLAY.
  - addr, song_time, combo, max_combo, score cleared.
  - judge_code cleared to 00.
- PLAY/HOLD timing: song_time increments on frame_tick and saturates at 16383.
- start in any state other than IDLE restarts the song: clear as in IDLE, go to PLAY.
- PLAY, evaluated in this priority order, at most one judgement per cycle:
  1. Head type 11, or addr >= CHART_LEN -> DONE.
  2. delta > G_WIN (window passed) -> MISS.
     - Tap: addr += 1.
     - Hold-start: addr += 2, skipping its hold-end.
     - A press in the same cycle is discarded.
  3. press with |delta| <= P_WIN -> PERFECT; otherwise press with |delta| <= G_WIN -> GOOD.
     - Tap: addr += 1.
     - Hold-start: addr += 1, go to HOLD, holding = 1.
  4. press with delta < -G_WIN is ignored, with no judgement.
- HOLD (head is hold-end):
  - key still held and delta >= 0 -> PERFECT, addr += 1, go to PLAY.
  - release with -G_WIN <= delta < 0 -> GOOD, addr += 1, go to PLAY.
  - release with delta < -G_WIN -> MISS, addr += 1, go to PLAY.
  - holding drops on the same edge as the state change.
- Judgement outputs:
  - judge_valid and judge_code are registered: they appear the cycle after the triggering condition.
  - addr updates on the same edge.
  - The ROM head is combinational, so the new head is visible in the following cycle.
- Score and combo:
  - PERFECT: score += 2. GOOD: score += 1. score saturates at 0xFFFF.
  - PERFECT or GOOD: combo += 1, saturating at 1023. MISS: combo = 0.
  - max_combo = max(max_combo, new combo), updated on the same edge.
- DONE:
  - done = 1; outputs frozen.
  - start -> PLAY with a restart as above.
- Reset mid-song returns immediately to the IDLE reset values.

Optional Feature:
- NOTE_JUDGE_AUTOPLAY_EN defined: an internal press is generated when delta == 0 in PLAY, and key_level is ignored.
  - In HOLD the key is treated as held.
  - Every note judges PERFECT.
- Not defined: only key_level drives judging.

Test Plan:
- Tap hit: head 0x0047, press at song_time 71 -> PERFECT; addr 0->1; score 2; combo 1.
- Good and early-ignore: head T=100, press at 95 -> GOOD (score +1); separate case with head T=100, press at 90 -> no judge_valid, addr unchanged.
- Miss by timeout: head T=100, no press, song_time reaches 107 -> MISS; combo 0; addr += 1; a press in that same cycle produces no second judgement.
- Hold pair 0x4235 / 0x8247 (T=565, 583): press at 565 -> PERFECT, holding=1; still held at 583 -> PERFECT, holding=0, addr += 2 in total. Repeat with release at 570 -> MISS.
- End/restart: addr = CHART_LEN -> done=1; pulse start -> addr 0, score 0, done 0. Assert Reset mid-hold -> all outputs at reset values asynchronously.
